// File: rtl/ula_pkg.sv
// Shared encodings for the sequential ULA: op codes, FSM states, flag positions.
package ula_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int F_Z = 0;
  localparam int F_C = 1;
  localparam int F_N = 2;
  localparam int F_V = 3;

  // Place the four status bits at their fixed positions.
  function automatic logic [3:0] pack_flags(input logic v, input logic n,
                                            input logic c, input logic z);
    logic [3:0] f;
    f      = '0;
    f[F_V] = v;
    f[F_N] = n;
    f[F_C] = c;
    f[F_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/ula_core.sv
// Combinational single-step ALU: ADD, SUB, AND, OR, XOR, NOT A with flags.
// SHL/MUL codes produce zero here; the sequencer handles them itself.
module ula_core
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic [3:0]       flags
);

  logic             c;
  logic             v;
  logic [WIDTH:0]   sum;

  // Result, carry/borrow and signed overflow for the selected op.
  always_comb begin
    y   = '0;
    c   = 1'b0;
    v   = 1'b0;
    sum = '0;
    case (op)
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        y   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // The extended top bit of the difference is the unsigned borrow.
        sum = {1'b0, a} - {1'b0, b};
        y   = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      default: y = '0;
    endcase
    flags = pack_flags(v, y[WIDTH-1], c, (y == '0));
  end

endmodule

// File: rtl/ula_seq.sv
// Handshaked sequential ULA: one op in flight, registered result and flags,
// accumulator operand mode, bit-serial SHL and shift-add MUL.
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             use_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [3:0]       flags
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;       // operand A; also the SHL shift register
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sh_none_q, sh_none_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mpl_q, mpl_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic [3:0]         flags_q, flags_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [WIDTH-1:0]   core_y;
  logic [3:0]         core_flags;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   res_y;
  logic [3:0]         res_flags;
  logic [WIDTH-1:0]   opa;
  logic [SHW-1:0]     shamt;

  ula_core #(.WIDTH(WIDTH)) u_core (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .y     (core_y),
    .flags (core_flags)
  );

  assign opa   = use_acc ? acc_q : a;
  assign shamt = b[SHW-1:0];

  // Value the result registers take on the final BUSY cycle.
  always_comb begin
    prod_nxt  = prod_q + (mpl_q[0] ? mcand_q : '0);
    res_y     = core_y;
    res_flags = core_flags;
    case (op_q)
      OP_SHL: begin
        // A zero shift amount still spends one cycle but shifts nothing.
        res_y     = sh_none_q ? a_q : {a_q[WIDTH-2:0], 1'b0};
        res_flags = pack_flags(1'b0, res_y[WIDTH-1],
                               sh_none_q ? 1'b0 : a_q[WIDTH-1], (res_y == '0));
      end
      OP_MUL: begin
        res_y     = prod_nxt[WIDTH-1:0];
        res_flags = pack_flags(1'b0, res_y[WIDTH-1],
                               |prod_nxt[2*WIDTH-1:WIDTH], (res_y == '0));
      end
      default: ;
    endcase
  end

  // FSM next state, step counter and datapath updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    sh_none_d   = sh_none_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;
    mpl_d       = mpl_q;
    acc_d       = acc_q;
    s_d         = s_q;
    flags_d     = flags_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = BUSY;
          in_ready_d = 1'b0;
          op_d       = op;
          a_d        = opa;
          b_d        = b;
          sh_none_d  = (shamt == '0);
          mcand_d    = {{WIDTH{1'b0}}, opa};
          mpl_d      = b;
          prod_d     = '0;
          case (op)
            OP_SHL:  cnt_d = (shamt == '0) ? CW'(1) : CW'(shamt);
            OP_MUL:  cnt_d = CW'(WIDTH);
            default: cnt_d = CW'(1);
          endcase
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q == OP_SHL && !sh_none_q) a_d = {a_q[WIDTH-2:0], 1'b0};
        if (op_q == OP_MUL) begin
          prod_d  = prod_nxt;
          mcand_d = {mcand_q[2*WIDTH-2:0], 1'b0};
          mpl_d   = {1'b0, mpl_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(1)) begin
          state_d     = DONE;
          s_d         = res_y;
          flags_d     = res_flags;
          acc_d       = res_y;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= OP_ADD;
      a_q         <= '0;
      b_q         <= '0;
      sh_none_q   <= 1'b0;
      mcand_q     <= '0;
      prod_q      <= '0;
      mpl_q       <= '0;
      acc_q       <= '0;
      s_q         <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sh_none_q   <= sh_none_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
      mpl_q       <= mpl_d;
      acc_q       <= acc_d;
      s_q         <= s_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq (WIDTH=8): latency, results, flags, acc chaining,
// backpressure and mid-operation reset.
module tb_ula_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic [2:0] op_i;
  logic       use_acc_i;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] s;
  logic [3:0] flags;

  int checks   = 0;
  int failures = 0;

  ula_seq #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .op        (op_i),
    .use_acc   (use_acc_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then step off it before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, check latency exactly, check result, then complete handshake.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] av,
                       input logic [7:0] bv, input logic ua, input int n,
                       input logic [7:0] se, input logic [3:0] fe);
    op_i = o; a_i = av; b_i = bv; use_acc_i = ua; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; a_i = 8'h5A; b_i = 8'hA5; op_i = 3'd7; use_acc_i = 1'b0;
    chk({tag, "_busy_rdy"}, 16'(in_ready), 16'h0);
    chk({tag, "_early0"}, 16'(out_valid), 16'h0);
    for (int i = 1; i < n; i++) begin
      tick();
      chk({tag, "_early"}, 16'(out_valid), 16'h0);
    end
    tick();
    chk({tag, "_vld"}, 16'(out_valid), 16'h1);
    chk({tag, "_s"}, 16'(s), 16'(se));
    chk({tag, "_flags"}, 16'(flags), 16'(fe));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_rdy"}, 16'(in_ready), 16'h1);
    chk({tag, "_idle_vld"}, 16'(out_valid), 16'h0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a_i = '0; b_i = '0; op_i = '0;
    use_acc_i = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_in_ready", 16'(in_ready), 16'h1);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_s", 16'(s), 16'h00);
    chk("rst_flags", 16'(flags), 16'h0);
    tick();
    chk("idle_in_ready", 16'(in_ready), 16'h1);
    chk("idle_out_valid", 16'(out_valid), 16'h0);

    // flags {V,N,C,Z}
    do_op("add_ovf",  3'd0, 8'h7F, 8'h01, 1'b0, 1, 8'h80, 4'b1100);
    do_op("sub_brw",  3'd1, 8'h00, 8'h01, 1'b0, 1, 8'hFF, 4'b0110);
    do_op("sub_ovf",  3'd1, 8'h80, 8'h01, 1'b0, 1, 8'h7F, 4'b1000);
    do_op("add_wrap", 3'd0, 8'hFF, 8'h01, 1'b0, 1, 8'h00, 4'b0011);
    do_op("and",      3'd2, 8'hF0, 8'h3C, 1'b0, 1, 8'h30, 4'b0000);
    do_op("or",       3'd3, 8'h0F, 8'hF0, 1'b0, 1, 8'hFF, 4'b0100);
    do_op("xor",      3'd4, 8'h55, 8'h55, 1'b0, 1, 8'h00, 4'b0001);
    do_op("not",      3'd5, 8'h0F, 8'h00, 1'b0, 1, 8'hF0, 4'b0100);
    do_op("shl3",     3'd6, 8'h81, 8'h03, 1'b0, 3, 8'h08, 4'b0000);
    do_op("shl_c",    3'd6, 8'h40, 8'h02, 1'b0, 2, 8'h00, 4'b0011);
    do_op("shl0",     3'd6, 8'h81, 8'h08, 1'b0, 1, 8'h81, 4'b0100);
    do_op("mul_hi",   3'd7, 8'hFF, 8'hFF, 1'b0, 8, 8'h01, 4'b0010);
    do_op("mul",      3'd7, 8'h10, 8'h10, 1'b0, 8, 8'h00, 4'b0011);
    do_op("acc_add",  3'd0, 8'hAA, 8'h05, 1'b1, 1, 8'h05, 4'b0000);

    // Backpressure: result held while out_ready stays low; new bundle ignored.
    op_i = 3'd0; a_i = 8'h03; b_i = 8'h04; use_acc_i = 1'b0; in_valid = 1'b1;
    tick();
    op_i = 3'd1; a_i = 8'h10; b_i = 8'h01;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", 16'(out_valid), 16'h1);
      chk("bp_s", 16'(s), 16'h07);
      chk("bp_flags", 16'(flags), 16'h0);
      chk("bp_in_ready", 16'(in_ready), 16'h0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_rel_rdy", 16'(in_ready), 16'h1);
    chk("bp_rel_vld", 16'(out_valid), 16'h0);

    // acc now holds 0x07; reset mid-MUL must clear it and emit no result.
    op_i = 3'd7; a_i = 8'h03; b_i = 8'h03; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_rdy", 16'(in_ready), 16'h1);
    chk("mrst_vld", 16'(out_valid), 16'h0);
    chk("mrst_s", 16'(s), 16'h00);
    chk("mrst_flags", 16'(flags), 16'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("mrst_no_vld", 16'(out_valid), 16'h0);
    end
    do_op("mrst_acc", 3'd0, 8'hAA, 8'h05, 1'b1, 1, 8'h05, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
